round_key_buffer: RTL and testbench

//  Parametrised multi-bank round-key buffer for the AES LUT core. Accepts a
//  key schedule as a stream of words from the AXI slave, assembles each

---
 rtl/round_key_buffer_if.sv | 30 +++
 rtl/round_key_buffer.sv | 91 +++++++++
 tb/tb_round_key_buffer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/round_key_buffer_if.sv
// Key-word load stream and wide round-key output of round_key_buffer.
// master: key producer / cipher consumer side; slave: the buffer itself.
interface round_key_buffer_if #(
   parameter int unsigned WORD_W    = 32,
   parameter int unsigned NUM_WORDS = 60,
   parameter int unsigned NUM_BANKS = 2
);
   localparam int unsigned CNT_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

   logic                        wr_valid;
   logic                        wr_ready;
   logic [WORD_W-1:0]           wr_data;
   logic                        wr_abort;
   logic [CNT_W-1:0]            wr_count;
   logic                        key_valid;
   logic                        key_ready;
   logic [WORD_W*NUM_WORDS-1:0] key_out;
   logic [BANK_W-1:0]           key_bank;

   modport master (
      output wr_valid, wr_data, wr_abort, key_ready,
      input  wr_ready, wr_count, key_valid, key_out, key_bank
   );

   modport slave (
      input  wr_valid, wr_data, wr_abort, key_ready,
      output wr_ready, wr_count, key_valid, key_out, key_bank
   );
endinterface

// File: rtl/round_key_buffer.sv
// Multi-bank ping-pong round-key buffer: assembles key schedules word by word
// and presents them as one wide bus. Define KEYBUF_ZEROIZE_EN to wipe banks on consume/abort.
module round_key_buffer #(
   parameter int unsigned WORD_W    = 32,
   parameter int unsigned NUM_WORDS = 60,
   parameter int unsigned NUM_BANKS = 2
) (
   input  logic               clk,
   input  logic               reset,
   round_key_buffer_if.slave  bus
);
   localparam int unsigned CNT_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(NUM_WORDS - 1);
   localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

   logic [WORD_W-1:0]    mem [NUM_BANKS][NUM_WORDS];
   logic [NUM_BANKS-1:0] full;
   logic [CNT_W-1:0]     wr_idx;
   logic [BANK_W-1:0]    wr_bank;
   logic [BANK_W-1:0]    rd_bank;

   logic accept;
   logic fill;
   logic consume;

   function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
      return (b == LAST_BANK) ? '0 : b + BANK_W'(1);
   endfunction

   // A fill can only target a non-full bank and a consume only a full one,
   // so the two never touch the same bank in one cycle.
   always_comb begin
      accept  = bus.wr_valid & ~full[wr_bank] & ~bus.wr_abort;
      fill    = accept & (wr_idx == LAST_IDX);
      consume = full[rd_bank] & bus.key_ready;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_idx  <= '0;
         wr_bank <= '0;
         rd_bank <= '0;
         full    <= '0;
      end else begin
         if (bus.wr_abort) begin
            wr_idx <= '0;
         end else if (accept) begin
            if (fill) begin
               wr_idx  <= '0;
               wr_bank <= next_bank(wr_bank);
            end else begin
               wr_idx <= wr_idx + CNT_W'(1);
            end
         end
         if (fill)
            full[wr_bank] <= 1'b1;
         if (consume) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= next_bank(rd_bank);
         end
      end
   end

   // Storage is not reset; key_out gating hides stale contents.
   always_ff @(posedge clk) begin
      if (accept)
         mem[wr_bank][wr_idx] <= bus.wr_data;
`ifdef KEYBUF_ZEROIZE_EN
      if (consume)
         for (int unsigned w = 0; w < NUM_WORDS; w++)
            mem[rd_bank][w] <= '0;
      if (bus.wr_abort)
         for (int unsigned w = 0; w < NUM_WORDS; w++)
            mem[wr_bank][w] <= '0;
`endif
   end

   always_comb begin
      bus.key_out = '0;
      for (int unsigned i = 0; i < NUM_WORDS; i++)
         if (full[rd_bank])
            bus.key_out[(NUM_WORDS-1-i)*WORD_W +: WORD_W] = mem[rd_bank][i];
   end

   assign bus.wr_ready  = ~full[wr_bank];
   assign bus.key_valid = full[rd_bank];
   assign bus.wr_count  = wr_idx;
   assign bus.key_bank  = rd_bank;

endmodule

// File: tb/tb_round_key_buffer.sv
// Directed bench for round_key_buffer: 60-word/2-bank and 44-word/1-bank instances.
// With KEYBUF_ZEROIZE_EN defined, bank storage is also inspected after consumes.
module tb_round_key_buffer;
   localparam int unsigned W  = 32;
   localparam int unsigned N  = 60;
   localparam int unsigned N1 = 44;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   round_key_buffer_if #(.WORD_W(W), .NUM_WORDS(N),  .NUM_BANKS(2)) bus  ();
   round_key_buffer_if #(.WORD_W(W), .NUM_WORDS(N1), .NUM_BANKS(1)) bus1 ();

   round_key_buffer #(.WORD_W(W), .NUM_WORDS(N), .NUM_BANKS(2)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave));
   round_key_buffer #(.WORD_W(W), .NUM_WORDS(N1), .NUM_BANKS(1)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1.slave));

   typedef enum int {OP_WR, OP_ABORT, OP_CONSUME} op_e;
   typedef struct {
      op_e         op;
      int          n;
      logic [31:0] base;
      logic        rdy_last;
      logic        e_wr_ready;
      logic        e_valid;
      logic        e_bank;
      int          e_count;
      logic [31:0] e_base;
   } vec_t;

   vec_t vecs[12];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_key(input string nm, input logic v, input logic [31:0] base);
      logic [31:0] e, a;
      int bad = -1;
      logic [31:0] ba = '0, be = '0;
      checks++;
      for (int i = 0; i < int'(N); i++) begin
         e = v ? base + 32'(i) : 32'h0;
         a = bus.key_out[(N-1-i)*W +: W];
         if (a !== e && bad < 0) begin bad = i; ba = a; be = e; end
      end
      if (bad >= 0) begin
         errors++;
         $display("FAIL %s word%0d actual=%0h required=%0h", nm, bad, ba, be);
      end
   endtask

   task automatic chk_key1(input string nm, input logic v, input logic [31:0] base);
      logic [31:0] e, a;
      int bad = -1;
      logic [31:0] ba = '0, be = '0;
      checks++;
      for (int i = 0; i < int'(N1); i++) begin
         e = v ? base + 32'(i) : 32'h0;
         a = bus1.key_out[(N1-1-i)*W +: W];
         if (a !== e && bad < 0) begin bad = i; ba = a; be = e; end
      end
      if (bad >= 0) begin
         errors++;
         $display("FAIL %s word%0d actual=%0h required=%0h", nm, bad, ba, be);
      end
   endtask

   // Writes n words base..base+n-1; key_ready is raised only with the last word.
   task automatic wr_words(input int n, input logic [31:0] base, input logic rdy_last);
      int t;
      for (int i = 0; i < n; i++) begin
         bus.wr_valid  = 1'b1;
         bus.wr_data   = base + 32'(i);
         bus.key_ready = (i == n-1) ? rdy_last : 1'b0;
         t = 0;
         while (bus.wr_ready !== 1'b1 && t < 200) begin step(); t++; end
         if (t >= 200) begin
            checks++; errors++;
            $display("FAIL wr_timeout word%0d actual=stalled required=ready", i);
         end
         step();
      end
      bus.wr_valid  = 1'b0;
      bus.key_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{OP_WR,      59, 32'h1,        1'b0, 1'b1, 1'b0, 1'b0, 59, 32'h0};
      vecs[1]  = '{OP_WR,       1, 32'h3C,       1'b0, 1'b1, 1'b1, 1'b0,  0, 32'h1};
      vecs[2]  = '{OP_WR,      60, 32'h100,      1'b0, 1'b0, 1'b1, 1'b0,  0, 32'h1};
      vecs[3]  = '{OP_CONSUME,  0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1,  0, 32'h100};
      vecs[4]  = '{OP_CONSUME,  0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0,  0, 32'h0};
      vecs[5]  = '{OP_CONSUME,  0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0,  0, 32'h0};
      vecs[6]  = '{OP_WR,      17, 32'hDEAD0000, 1'b0, 1'b1, 1'b0, 1'b0, 17, 32'h0};
      vecs[7]  = '{OP_ABORT,    0, 32'hBADBAD00, 1'b0, 1'b1, 1'b0, 1'b0,  0, 32'h0};
      vecs[8]  = '{OP_WR,      60, 32'h200,      1'b0, 1'b1, 1'b1, 1'b0,  0, 32'h200};
      vecs[9]  = '{OP_WR,      59, 32'h300,      1'b0, 1'b1, 1'b1, 1'b0, 59, 32'h200};
      vecs[10] = '{OP_WR,       1, 32'h33B,      1'b1, 1'b1, 1'b1, 1'b1,  0, 32'h300};
      vecs[11] = '{OP_CONSUME,  0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0,  0, 32'h0};

      reset = 1'b1;
      bus.wr_valid = 1'b0; bus.wr_data = '0; bus.wr_abort = 1'b0; bus.key_ready = 1'b0;
      bus1.wr_valid = 1'b0; bus1.wr_data = '0; bus1.wr_abort = 1'b0; bus1.key_ready = 1'b0;
      step(); step();
      reset = 1'b0;

      chk("rst_wr_ready",  64'(bus.wr_ready),  64'd1);
      chk("rst_key_valid", 64'(bus.key_valid), 64'd0);
      chk("rst_wr_count",  64'(bus.wr_count),  64'd0);
      chk("rst_key_bank",  64'(bus.key_bank),  64'd0);
      chk_key("rst_key_out", 1'b0, 32'h0);
      chk("rst1_wr_ready", 64'(bus1.wr_ready), 64'd1);

      for (int r = 0; r < 12; r++) begin
         case (vecs[r].op)
            OP_WR: wr_words(vecs[r].n, vecs[r].base, vecs[r].rdy_last);
            OP_ABORT: begin
               bus.wr_valid = 1'b1; bus.wr_data = vecs[r].base; bus.wr_abort = 1'b1;
               step();
               bus.wr_valid = 1'b0; bus.wr_abort = 1'b0;
            end
            default: begin
               bus.key_ready = 1'b1;
               step();
               bus.key_ready = 1'b0;
            end
         endcase
         chk($sformatf("row%0d_wr_ready", r),  64'(bus.wr_ready),  64'(vecs[r].e_wr_ready));
         chk($sformatf("row%0d_key_valid", r), 64'(bus.key_valid), 64'(vecs[r].e_valid));
         chk($sformatf("row%0d_key_bank", r),  64'(bus.key_bank),  64'(vecs[r].e_bank));
         chk($sformatf("row%0d_wr_count", r),  64'(bus.wr_count),  64'(vecs[r].e_count));
         chk_key($sformatf("row%0d_key_out", r), vecs[r].e_valid, vecs[r].e_base);
      end

`ifdef KEYBUF_ZEROIZE_EN
      begin
         logic nz = 1'b0;
         for (int i = 0; i < int'(N); i++)
            if (dut.mem[0][i] !== '0 || dut.mem[1][i] !== '0) nz = 1'b1;
         chk("zeroize_mem", 64'(nz), 64'd0);
      end
`endif

      // Reset with bank 0 held and bank 1 half loaded.
      wr_words(60, 32'h400, 1'b0);
      wr_words(30, 32'h500, 1'b0);
      chk("midload_wr_count",  64'(bus.wr_count),  64'd30);
      chk("midload_key_valid", 64'(bus.key_valid), 64'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mrst_key_valid", 64'(bus.key_valid), 64'd0);
      chk("mrst_wr_count",  64'(bus.wr_count),  64'd0);
      chk("mrst_wr_ready",  64'(bus.wr_ready),  64'd1);
      chk("mrst_key_bank",  64'(bus.key_bank),  64'd0);
      chk_key("mrst_key_out", 1'b0, 32'h0);

      // Single-bank instance: fill, stalled writes, consume.
      for (int i = 0; i < int'(N1); i++) begin
         int t = 0;
         bus1.wr_valid = 1'b1;
         bus1.wr_data  = 32'h1000 + 32'(i);
         while (bus1.wr_ready !== 1'b1 && t < 200) begin step(); t++; end
         if (t >= 200) begin
            checks++; errors++;
            $display("FAIL b1_wr_timeout word%0d actual=stalled required=ready", i);
         end
         step();
      end
      bus1.wr_valid = 1'b0;
      chk("b1_full_wr_ready",  64'(bus1.wr_ready),  64'd0);
      chk("b1_full_key_valid", 64'(bus1.key_valid), 64'd1);
      chk("b1_full_key_bank",  64'(bus1.key_bank),  64'd0);
      chk_key1("b1_full_key_out", 1'b1, 32'h1000);

      bus1.wr_valid = 1'b1; bus1.wr_data = 32'hBAD;
      step(); step(); step();
      bus1.wr_valid = 1'b0;
      chk("b1_stall_wr_count", 64'(bus1.wr_count), 64'd0);
      chk_key1("b1_stall_key_out", 1'b1, 32'h1000);

      bus1.key_ready = 1'b1;
      step();
      bus1.key_ready = 1'b0;
      chk("b1_cons_wr_ready",  64'(bus1.wr_ready),  64'd1);
      chk("b1_cons_key_valid", 64'(bus1.key_valid), 64'd0);
      chk_key1("b1_cons_key_out", 1'b0, 32'h0);
`ifdef KEYBUF_ZEROIZE_EN
      begin
         logic nz = 1'b0;
         for (int i = 0; i < int'(N1); i++)
            if (dut1.mem[0][i] !== '0) nz = 1'b1;
         chk("b1_zeroize_mem", 64'(nz), 64'd0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
